// File: rtl/cdm16_int_ctrl.sv
// Interrupt/exception controller for the cdm16 core: latches IRQ edges and core faults,
// arbitrates by fixed priority with nesting, and offers one registered exception at a time.
module cdm16_int_ctrl #(
    parameter int unsigned N_IRQ     = 8,
    parameter logic [15:0] VEC_BASE  = 16'h0000,
    parameter int unsigned IRQ_VEC0  = 16,
    parameter int unsigned FAULT_VEC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             fault,
    input  logic             int_en,
    input  logic             fetch,
    input  logic             int_ack,
    input  logic             rti,
    output logic             exc_triggered,
    output logic             virtual_instruction,
    output logic [15:0]      vector_addr,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);
    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state;
    logic [N_IRQ-1:0] irq_q;
    logic             fault_pend;
    logic             sel_fault;
    logic [IDX_W-1:0] sel_idx;

    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] rti_clr;
    logic [N_IRQ-1:0] is_after_rti;
    logic [N_IRQ-1:0] sel_mask;
    logic             blocked;
    logic             elig_valid;
    logic [IDX_W-1:0] elig_idx;
    logic             ack_irq;
    logic             ack_fault;
    logic [15:0]      nxt_vec;
    logic [15:0]      nxt_addr;

    always_comb begin
        irq_edge   = irq & ~irq_q;
        rti_clr    = '0;
        blocked    = 1'b0;
        elig_valid = 1'b0;
        elig_idx   = '0;
        // Lowest in-service level blocks itself and everything above it.
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (!blocked && in_service[i]) begin
                blocked    = 1'b1;
                rti_clr[i] = 1'b1;
            end
            if (!blocked && !elig_valid && pending[i]) begin
                elig_valid = 1'b1;
                elig_idx   = IDX_W'(i);
            end
        end
        is_after_rti = rti ? (in_service & ~rti_clr) : in_service;
        sel_mask     = N_IRQ'(1) << sel_idx;
        ack_irq      = (state == OFFER) && int_ack && !sel_fault;
        ack_fault    = (state == OFFER) && int_ack && sel_fault;
        nxt_vec      = fault_pend ? 16'(FAULT_VEC) : 16'(IRQ_VEC0) + 16'(elig_idx);
        nxt_addr     = VEC_BASE + (nxt_vec << 2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= IDLE;
            irq_q               <= irq;
            pending             <= '0;
            in_service          <= '0;
            fault_pend          <= 1'b0;
            sel_fault           <= 1'b0;
            sel_idx             <= '0;
            exc_triggered       <= 1'b0;
            virtual_instruction <= 1'b0;
            vector_addr         <= '0;
        end else begin
            irq_q      <= irq;
            fault_pend <= fault | (fault_pend & ~ack_fault);
            // New edges win over the ack clear; rti clear is applied before the ack set.
            if (ack_irq) begin
                pending    <= (pending & ~sel_mask) | irq_edge;
                in_service <= is_after_rti | sel_mask;
            end else begin
                pending    <= pending | irq_edge;
                in_service <= is_after_rti;
            end

            case (state)
                IDLE: begin
                    if (fetch && (fault_pend || (int_en && elig_valid))) begin
                        state               <= OFFER;
                        sel_fault           <= fault_pend;
                        sel_idx             <= elig_idx;
                        exc_triggered       <= 1'b1;
                        virtual_instruction <= ~fault_pend;
                        vector_addr         <= nxt_addr;
                    end
                end
                OFFER: begin
                    if (int_ack || (!sel_fault && !int_en)) begin
                        state               <= IDLE;
                        exc_triggered       <= 1'b0;
                        virtual_instruction <= 1'b0;
                        vector_addr         <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
